// File: rtl/carpark_gate_ctrl.sv
// -----------------------------------------------------------------------------
// carpark_gate_ctrl
//
// Controller for the single shared barrier lane of the car park. It arbitrates
// entry and exit requests for the one barrier, sequences the barrier motor
// through raise / wait-for-passage / lower phases, and keeps the occupancy
// count against a fixed capacity. Clocked from the 100 Hz system clock.
//
// Build option:
//   CARPARK_EXIT_PRIORITY_EN  defined   -> exit always wins a tie in IDLE
//                             undefined -> round-robin on ties (entry first)
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   req_in       in   entry request (level, held until granted)
//   req_out      in   exit request (level, held until granted)
//   pass         in   vehicle-in-gate-zone sensor (level, synchronous)
//   grant_in     out  one-cycle pulse, entry transaction accepted
//   grant_out    out  one-cycle pulse, exit transaction accepted
//   motor_up     out  raise barrier
//   motor_down   out  lower barrier
//   busy         out  high whenever the controller is not IDLE
//   count        out  current occupancy
//   full         out  count == CAPACITY
//   empty        out  count == 0
//   timeout_err  out  one-cycle pulse, passage wait timed out
// -----------------------------------------------------------------------------
module carpark_gate_ctrl #(
    parameter int CAPACITY     = 16,
    parameter int CNT_W        = 5,
    parameter int OPEN_CYCLES  = 200,
    parameter int CLOSE_CYCLES = 200,
    parameter int PASS_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic             req_out,
    input  logic             pass,
    output logic             grant_in,
    output logic             grant_out,
    output logic             motor_up,
    output logic             motor_down,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             timeout_err
);

    // One phase counter is shared by all timed states, so size it for the longest.
    localparam int PH_MAX_OC = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
    localparam int PH_MAX    = (PH_MAX_OC > PASS_TIMEOUT) ? PH_MAX_OC : PASS_TIMEOUT;
    localparam int PH_W      = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  OPEN_LAST  = PH_W'(OPEN_CYCLES - 1);
    localparam logic [PH_W-1:0]  CLOSE_LAST = PH_W'(CLOSE_CYCLES - 1);
    localparam logic [PH_W-1:0]  WAIT_LAST  = PH_W'(PASS_TIMEOUT - 1);
    localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
    localparam logic [CNT_W-1:0] CAP_V      = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPENING,
        S_WAIT_PASS,
        S_CLOSING
    } state_t;

    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } dir_t;

    state_t           state_q;
    dir_t             dir_q;       // direction of the transaction in progress
`ifndef CARPARK_EXIT_PRIORITY_EN
    dir_t             last_q;      // direction of the most recent grant
`endif
    logic [PH_W-1:0]  phase_q;
    logic             pass_q;      // previous pass sample, for falling-edge detect
    logic             counted_q;   // passage already counted in this transaction
    logic [CNT_W-1:0] count_q;
    logic             full_q;
    logic             empty_q;
    logic             grant_in_q;
    logic             grant_out_q;
    logic             motor_up_q;
    logic             motor_down_q;
    logic             busy_q;
    logic             timeout_q;

    logic             elig_in;
    logic             elig_out;
    logic             pick_in;
    logic             pick_out;
    logic             pass_fall;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d   = count_q;
        elig_in   = req_in && !full_q;
        elig_out  = req_out && !empty_q;
`ifdef CARPARK_EXIT_PRIORITY_EN
        pick_out  = elig_out;
`else
        // On a tie, serve the direction that was not served last time.
        pick_out  = elig_out && (!elig_in || (last_q == DIR_IN));
`endif
        pick_in   = elig_in && !pick_out;
        pass_fall = pass_q && !pass;

        // Occupancy after a counted passage, clamped at both ends.
        if (dir_q == DIR_IN) begin
            if (count_q < CAP_V) begin
                count_d = count_q + CNT_ONE;
            end
        end else if (count_q != '0) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dir_q        <= DIR_IN;
`ifndef CARPARK_EXIT_PRIORITY_EN
            last_q       <= DIR_OUT;
`endif
            phase_q      <= '0;
            pass_q       <= 1'b0;
            counted_q    <= 1'b0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            grant_in_q   <= 1'b0;
            grant_out_q  <= 1'b0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            pass_q      <= pass;
            grant_in_q  <= 1'b0;
            grant_out_q <= 1'b0;
            timeout_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (pick_in || pick_out) begin
                        state_q     <= S_OPENING;
                        dir_q       <= pick_out ? DIR_OUT : DIR_IN;
`ifndef CARPARK_EXIT_PRIORITY_EN
                        last_q      <= pick_out ? DIR_OUT : DIR_IN;
`endif
                        grant_in_q  <= pick_in;
                        grant_out_q <= pick_out;
                        motor_up_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        phase_q     <= '0;
                    end
                end

                S_OPENING: begin
                    if (phase_q == OPEN_LAST) begin
                        state_q    <= S_WAIT_PASS;
                        motor_up_q <= 1'b0;
                        phase_q    <= '0;
                    end else begin
                        phase_q <= phase_q + PH_ONE;
                    end
                end

                S_WAIT_PASS: begin
                    if (pass_fall) begin
                        // After an obstacle reopen the car was already counted.
                        if (!counted_q) begin
                            count_q <= count_d;
                            full_q  <= (count_d == CAP_V);
                            empty_q <= (count_d == '0);
                        end
                        counted_q    <= 1'b1;
                        state_q      <= S_CLOSING;
                        motor_down_q <= 1'b1;
                        phase_q      <= '0;
                    end else if (phase_q == WAIT_LAST) begin
                        timeout_q    <= 1'b1;
                        state_q      <= S_CLOSING;
                        motor_down_q <= 1'b1;
                        phase_q      <= '0;
                    end else begin
                        phase_q <= phase_q + PH_ONE;
                    end
                end

                S_CLOSING: begin
                    if (pass) begin
                        // Something is under the barrier: go back up.
                        state_q      <= S_OPENING;
                        motor_down_q <= 1'b0;
                        motor_up_q   <= 1'b1;
                        phase_q      <= '0;
                    end else if (phase_q == CLOSE_LAST) begin
                        state_q      <= S_IDLE;
                        motor_down_q <= 1'b0;
                        busy_q       <= 1'b0;
                        counted_q    <= 1'b0;
                        phase_q      <= '0;
                    end else begin
                        phase_q <= phase_q + PH_ONE;
                    end
                end

                default: begin
                    state_q      <= S_IDLE;
                    motor_up_q   <= 1'b0;
                    motor_down_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign grant_in    = grant_in_q;
    assign grant_out   = grant_out_q;
    assign motor_up    = motor_up_q;
    assign motor_down  = motor_down_q;
    assign busy        = busy_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_carpark_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_carpark_gate_ctrl
//
// Directed bench for carpark_gate_ctrl. A phase/deadline model of the lane,
// written from the operating rules, is compared with every DUT output on each
// falling clock edge; directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_carpark_gate_ctrl;

    localparam int CAP = 16;
    localparam int CW  = 5;
    localparam int OC  = 200;
    localparam int CC  = 200;
    localparam int PT  = 1000;

`ifdef CARPARK_EXIT_PRIORITY_EN
    localparam bit EXIT_PRIO     = 1'b1;
    localparam int EXP_FIRST_IN  = 0;
    localparam int CNT_AFTER_T2  = 1;
`else
    localparam bit EXIT_PRIO     = 1'b0;
    localparam int EXP_FIRST_IN  = 1;
    localparam int CNT_AFTER_T2  = 3;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_in;
    logic          req_out;
    logic          pass;
    logic          grant_in;
    logic          grant_out;
    logic          motor_up;
    logic          motor_down;
    logic          busy;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          timeout_err;

    carpark_gate_ctrl #(
        .CAPACITY    (CAP),
        .CNT_W       (CW),
        .OPEN_CYCLES (OC),
        .CLOSE_CYCLES(CC),
        .PASS_TIMEOUT(PT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .req_out    (req_out),
        .pass       (pass),
        .grant_in   (grant_in),
        .grant_out  (grant_out),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .busy       (busy),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // The lane is in one of four phases; each timed phase ends at an absolute
    // edge number (deadline) rather than via a running counter.
    typedef enum {PH_IDLE, PH_RAISE, PH_OPEN, PH_LOWER} phase_e;

    int     m_t       = 0;
    bit     m_valid   = 1'b0;
    phase_e m_ph      = PH_IDLE;
    int     m_deadline;
    int     m_count   = 0;
    bit     m_counted;
    bit     m_entry;
    bit     m_last_out;
    bit     m_prev_pass;
    bit     m_gi, m_go, m_terr;

    always @(posedge clk) begin : model
        bit fall, ein, eout, take_out;
        m_t++;
        if (rst) begin
            m_valid     = 1'b1;
            m_ph        = PH_IDLE;
            m_count     = 0;
            m_counted   = 1'b0;
            m_last_out  = 1'b1;
            m_prev_pass = 1'b0;
            m_gi        = 1'b0;
            m_go        = 1'b0;
            m_terr      = 1'b0;
        end else begin
            fall        = m_prev_pass && !pass;
            m_prev_pass = pass;
            m_gi        = 1'b0;
            m_go        = 1'b0;
            m_terr      = 1'b0;
            case (m_ph)
                PH_IDLE: begin
                    ein  = req_in && (m_count < CAP);
                    eout = req_out && (m_count > 0);
                    if (ein && eout) take_out = EXIT_PRIO ? 1'b1 : !m_last_out;
                    else             take_out = eout;
                    if (ein || eout) begin
                        m_entry    = !take_out;
                        m_gi       = !take_out;
                        m_go       = take_out;
                        m_last_out = take_out;
                        m_ph       = PH_RAISE;
                        m_deadline = m_t + OC;
                    end
                end
                PH_RAISE: begin
                    if (m_t == m_deadline) begin
                        m_ph       = PH_OPEN;
                        m_deadline = m_t + PT;
                    end
                end
                PH_OPEN: begin
                    if (fall) begin
                        if (!m_counted) begin
                            if (m_entry && m_count < CAP) m_count = m_count + 1;
                            if (!m_entry && m_count > 0)  m_count = m_count - 1;
                        end
                        m_counted  = 1'b1;
                        m_ph       = PH_LOWER;
                        m_deadline = m_t + CC;
                    end else if (m_t == m_deadline) begin
                        m_terr     = 1'b1;
                        m_ph       = PH_LOWER;
                        m_deadline = m_t + CC;
                    end
                end
                PH_LOWER: begin
                    if (pass) begin
                        m_ph       = PH_RAISE;
                        m_deadline = m_t + OC;
                    end else if (m_t == m_deadline) begin
                        m_ph      = PH_IDLE;
                        m_counted = 1'b0;
                    end
                end
                default: m_ph = PH_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ compare
    always @(negedge clk) begin
        if (m_valid) begin
            check("grant_in",    grant_in,    m_gi);
            check("grant_out",   grant_out,   m_go);
            check("motor_up",    motor_up,    m_ph == PH_RAISE);
            check("motor_down",  motor_down,  m_ph == PH_LOWER);
            check("busy",        busy,        m_ph != PH_IDLE);
            check("count",       count,       m_count);
            check("full",        full,        m_count == CAP);
            check("empty",       empty,       m_count == 0);
            check("timeout_err", timeout_err, m_terr);
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic wait_grant(output bit gi, output bit go, output int lat);
        gi  = 1'b0;
        go  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (grant_in === 1'b1 || grant_out === 1'b1) begin
                gi  = grant_in;
                go  = grant_out;
                lat = i;
                return;
            end
        end
        check("grant_wait_bound", 0, 1);
    endtask

    task automatic measure_up(output int n);
        n = 0;
        while (motor_up === 1'b1 && n < OC + 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic measure_down(output int n);
        n = 0;
        while (motor_down === 1'b1 && n < CC + 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Raise, hold pass for plen cycles in the open phase, then close.
    task automatic finish_txn(input int plen, output int nu, output int nd);
        measure_up(nu);
        pass = 1'b1;
        repeat (plen) @(negedge clk);
        pass = 1'b0;
        @(negedge clk);
        measure_down(nd);
    endtask

    task automatic simple_txn(input bit entry, input int plen);
        bit gi, go;
        int lat, nu, nd;
        if (entry) req_in = 1'b1;
        else       req_out = 1'b1;
        wait_grant(gi, go, lat);
        check("txn_dir", gi, entry);
        req_in  = 1'b0;
        req_out = 1'b0;
        finish_txn(plen, nu, nd);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, got busy=%0d expected finish", busy);
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        bit gi, go;
        int lat, nu, nd, n;

        req_in  = 1'b0;
        req_out = 1'b0;
        pass    = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_busy",  busy,  0);
        rst = 1'b0;

        // 1: single entry with a 50-cycle passage
        req_in = 1'b1;
        wait_grant(gi, go, lat);
        check("t1_grant_in", gi, 1);
        check("t1_latency",  lat, 1);
        check("t1_motor_up", motor_up, 1);
        check("t1_busy",     busy, 1);
        req_in = 1'b0;
        measure_up(nu);
        check("t1_up_len", nu, 200);
        pass = 1'b1;
        repeat (50) @(negedge clk);
        pass = 1'b0;
        @(negedge clk);
        check("t1_count",      count, 1);
        check("t1_motor_down", motor_down, 1);
        check("t1_empty",      empty, 0);
        measure_down(nd);
        check("t1_down_len", nd, 200);
        check("t1_idle",     busy, 0);

        // 2: bring count to 3 with an exit last, then two ties
        simple_txn(1'b1, 4);
        simple_txn(1'b1, 4);
        simple_txn(1'b1, 4);
        simple_txn(1'b0, 4);
        check("t2_pre_count", count, 3);
        req_in  = 1'b1;
        req_out = 1'b1;
        wait_grant(gi, go, lat);
        check("t2_first_in", gi, EXP_FIRST_IN);
        if (gi) req_in = 1'b0;
        else    req_out = 1'b0;
        @(negedge clk);
        req_in  = 1'b1;
        req_out = 1'b1;
        finish_txn(4, nu, nd);
        wait_grant(gi, go, lat);
        check("t2_second_out", go, 1);
        check("t2_second_in",  gi, 0);
        req_in  = 1'b0;
        req_out = 1'b0;
        finish_txn(4, nu, nd);
        check("t2_count", count, CNT_AFTER_T2);

        // 3: fill, entry blocked while full, exit frees a space
        for (int i = 0; i < CAP - CNT_AFTER_T2; i++) simple_txn(1'b1, 3);
        check("t3_count_full", count, 16);
        check("t3_full",       full, 1);
        req_in = 1'b1;
        repeat (30) @(negedge clk);
        check("t3_blocked_busy", busy, 0);
        req_out = 1'b1;
        wait_grant(gi, go, lat);
        check("t3_exit_grant", go, 1);
        check("t3_no_entry",   gi, 0);
        req_out = 1'b0;
        finish_txn(3, nu, nd);
        check("t3_count_15", count, 15);
        check("t3_not_full", full, 0);
        wait_grant(gi, go, lat);
        check("t3_entry_grant", gi, 1);
        check("t3_entry_lat",   lat, 1);
        req_in = 1'b0;
        finish_txn(3, nu, nd);
        check("t3_count_16", count, 16);

        // 4: passage timeout
        req_out = 1'b1;
        wait_grant(gi, go, lat);
        req_out = 1'b0;
        measure_up(nu);
        n = 0;
        while (timeout_err !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t4_timeout_at",  n, 1000);
        check("t4_count",       count, 16);
        check("t4_motor_down",  motor_down, 1);
        measure_down(nd);
        check("t4_down_len", nd, 200);
        check("t4_idle",     busy, 0);

        // 5: obstacle 50 cycles into closing
        req_out = 1'b1;
        wait_grant(gi, go, lat);
        req_out = 1'b0;
        measure_up(nu);
        pass = 1'b1;
        repeat (5) @(negedge clk);
        pass = 1'b0;
        @(negedge clk);
        check("t5_count_after_pass", count, 15);
        repeat (49) @(negedge clk);
        pass = 1'b1;
        @(negedge clk);
        check("t5_reopen_up",   motor_up, 1);
        check("t5_reopen_down", motor_down, 0);
        check("t5_no_grant",    grant_out, 0);
        measure_up(nu);
        check("t5_up_len", nu, 200);
        repeat (3) @(negedge clk);
        pass = 1'b0;
        @(negedge clk);
        check("t5_no_double", count, 15);
        check("t5_closing",   motor_down, 1);
        measure_down(nd);
        check("t5_down_len", nd, 200);
        check("t5_idle",     busy, 0);

        // 6: reset during OPENING
        req_in = 1'b1;
        wait_grant(gi, go, lat);
        req_in = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_motor_up",   motor_up, 0);
        check("t6_motor_down", motor_down, 0);
        check("t6_count",      count, 0);
        check("t6_empty",      empty, 1);
        check("t6_busy",       busy, 0);
        check("t6_grant",      grant_in, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_stays_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
